tdc_stream_rx: RTL and testbench
================================

Name: tdc_stream_rx

Overview:
- Core-side counterpart of the TDC output stream. On a host request it issues the TDC_start pulse, then sinks the TDC result stream (TDC_Odata/Oint/Onum/Olast/Ovalid, with TDC_Oready as backpressure) into a 4-entry frame buffer.
- Closes the frame on the last beat, on TDC_INT, or on timeout, then presents the frame to core logic through an indexed read port until it is acknowledged.

Parameters:
- DATA_W, 15, TDC depth-data width.
- INT_W, 5, intensity width.
- START_CYC, 2, TDC_start pulse length in clk cycles (range 1..15).
- TIMEOUT_CYC, 64, maximum COLLECT cycles with no frame-closing event (range 2..1023).

Ports:
- clk  in  1  logic clock, the AXI-stream clock of the TDC output.
- rst  in  1  asynchronous, active-high reset.
- meas_req  in  1  single-cycle request to start a measurement.
- TDC_start  out  1  start pulse to the TDC.
- TDC_Odata  in  DATA_W  depth data beat.
- TDC_Oint  in  INT_W  intensity of the beat.
- TDC_Onum  in  2  beat index within the frame (0..3).
- TDC_Olast  in  1  last beat of the frame.
- TDC_Ovalid  in  1  beat valid.
- TDC_Oready  out  1  beat ready.
- TDC_INT  in  1  TDC interrupt; closes the frame.
- frame_valid  out  1  frame buffer holds a closed frame.
- frame_cnt  out  3  number of stored entries (0..4).
- rd_addr  in  2  read index.
- rd_data  out  DATA_W+INT_W  {Oint, Odata} of entry rd_addr, combinational from the buffer.
- frame_ack  in  1  host releases the frame.
- err_seq  out  1  an Onum value mismatched the expected index.
- err_ovf  out  1  more than 4 beats were offered.
- timeout  out  1  frame was closed by the timeout.

Behaviour:
- Reset values: all outputs are 0 and the FSM is IDLE. Reset is asynchronous, so TDC_start and TDC_Oready drop immediately, including mid-frame. Buffer contents after reset are don't-care.
- FSM state IDLE: Oready=0. meas_req moves to START and clears frame_cnt, err_seq, err_ovf, timeout and the beat index.
- FSM state START: TDC_start=1 for exactly START_CYC cycles, registered output, first high cycle is the cycle after meas_req. Then moves to COLLECT.
- FSM state COLLECT: Oready=1, registered, asserted from the first COLLECT cycle. Timeout counter starts at 0 on entry.
- Beat acceptance: a beat is accepted when Ovalid&&Oready.
  - If idx<4: store {Oint,Odata} at idx, then idx++ and frame_cnt++.
  - If idx==4: drop the beat and set err_ovf.
  - If Onum!=idx[1:0]: set err_seq; the beat is still stored.
- Close on last: an accepted beat with Olast moves to DONE the next cycle.
- Close on interrupt: TDC_INT high in COLLECT moves to DONE. If a beat is accepted in the same cycle, that beat is stored first.
- Close on timeout: the counter increments every COLLECT cycle without an accepted beat and resets on each accepted beat. When it reaches TIMEOUT_CYC-1 the FSM moves to DONE with timeout=1.
- Priority on the same cycle: Olast, then INT, then timeout. timeout is set only when it is the sole cause.
- FSM state DONE: Oready=0 and frame_valid=1. frame_cnt, the error flags and the buffer are held stable. frame_ack moves to IDLE and clears frame_valid the next cycle. meas_req is ignored in every state except IDLE.
- Other inputs: TDC_INT outside COLLECT is ignored. Ovalid outside COLLECT is not accepted, because Oready=0.
- rd_addr >= frame_cnt returns stale data, which is don't-care.
- Latency: meas_req to first TDC_start = 1 cycle; last beat to frame_valid = 1 cycle.

Decomposition:
- Package tdc_rx_pkg holds:
  - the state enum (IDLE, START, COLLECT, DONE);
  - FRAME_DEPTH=4;
  - the entry struct/width localparam (INT_W+DATA_W).
- One sub-module, tdc_rx_fbuf: a 4x(INT_W+DATA_W) register file with write-enable/index and an asynchronous read port.
- The FSM, counters and flags stay in the top module.

Test Plan:
- Normal frame: meas_req; 4 beats with Onum 0..3, data 0x0100/0x0200/0x0300/0x0400, Oint 1/5/9/11, Olast on beat 3 -> TDC_start high exactly 2 cycles; frame_valid one cycle after the last beat; frame_cnt=4; rd_addr=2 gives {9,0x0300}; no flags set.
- Backpressure/gap: Ovalid toggled with idle cycles; 2 beats, then TDC_INT -> frame_cnt=2, err flags 0, timeout 0, Oready low in DONE; Ovalid during DONE is not stored.
- Timeout: meas_req, no beats -> DONE after 64 COLLECT cycles with timeout=1 and frame_cnt=0; frame_ack returns to IDLE and clears frame_valid.
- Errors: beats with Onum 0,2 then 3 further beats with Olast on the fifth -> err_seq=1, err_ovf=1, frame_cnt=4, fifth beat's data is absent from the buffer.
- Simultaneous events: accepted beat with Olast=1 in the same cycle as TDC_INT and timeout expiry -> the beat is stored; timeout=0.
- Reset mid-COLLECT: rst asserted after 1 beat -> TDC_Oready and frame_valid are 0 immediately, FSM is IDLE; a new meas_req then runs a clean frame with frame_cnt starting at 0.

Source files
------------

// File: rtl/tdc_rx_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package     : tdc_rx_pkg                                           |
// | Description : Shared types and constants for the TDC stream        |
// |               receiver: FSM state encoding, frame depth and the    |
// |               frame-buffer entry width.                            |
// | Revision    : 1.0  initial release                                 |
// +--------------------------------------------------------------------+
package tdc_rx_pkg;

  localparam int FRAME_DEPTH = 4;

  // Default entry layout is {Oint, Odata}.
  localparam int DEF_DATA_W  = 15;
  localparam int DEF_INT_W   = 5;
  localparam int DEF_ENTRY_W = DEF_INT_W + DEF_DATA_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    COLLECT = 2'd2,
    DONE    = 2'd3
  } state_t;

  function automatic int entry_w(input int data_w, input int int_w);
    return data_w + int_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tdc_rx_fbuf.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : tdc_rx_fbuf                                          |
// | Description : FRAME_DEPTH x ENTRY_W register file, one write port, |
// |               one asynchronous read port.                          |
// | Ports       : clk     - clock                                      |
// |               wr_en   - write strobe                               |
// |               wr_idx  - write index                                |
// |               wr_data - write data                                 |
// |               rd_idx  - read index                                 |
// |               rd_data - read data (combinational)                  |
// | Revision    : 1.0  initial release                                 |
// +--------------------------------------------------------------------+
module tdc_rx_fbuf
  import tdc_rx_pkg::*;
#(
  parameter int ENTRY_W = DEF_ENTRY_W
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [1:0]         wr_idx,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic [1:0]         rd_idx,
  output logic [ENTRY_W-1:0] rd_data
);

  // Contents are don't-care after reset, so the array carries no reset.
  logic [ENTRY_W-1:0] mem [FRAME_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule
`default_nettype wire

// File: rtl/tdc_stream_rx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : tdc_stream_rx                                        |
// | Description : Issues the TDC start pulse on a host request, sinks  |
// |               up to FRAME_DEPTH result beats into a frame buffer,  |
// |               closes the frame on Olast / TDC_INT / timeout and    |
// |               holds it for an indexed host read until frame_ack.   |
// | Ports       : clk, rst         - clock, async active-high reset    |
// |               meas_req         - start a measurement (IDLE only)   |
// |               TDC_start        - start pulse, START_CYC cycles     |
// |               TDC_O*           - TDC result stream + backpressure  |
// |               TDC_INT          - TDC interrupt, closes the frame   |
// |               frame_valid/cnt  - closed-frame status               |
// |               rd_addr/rd_data  - indexed buffer read               |
// |               frame_ack        - host releases the frame           |
// |               err_seq/err_ovf/timeout - frame status flags         |
// | Revision    : 1.0  initial release                                 |
// +--------------------------------------------------------------------+
module tdc_stream_rx
  import tdc_rx_pkg::*;
#(
  parameter int DATA_W      = 15,
  parameter int INT_W       = 5,
  parameter int START_CYC   = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    meas_req,
  output logic                    TDC_start,
  input  logic [DATA_W-1:0]       TDC_Odata,
  input  logic [INT_W-1:0]        TDC_Oint,
  input  logic [1:0]              TDC_Onum,
  input  logic                    TDC_Olast,
  input  logic                    TDC_Ovalid,
  output logic                    TDC_Oready,
  input  logic                    TDC_INT,
  output logic                    frame_valid,
  output logic [2:0]              frame_cnt,
  input  logic [1:0]              rd_addr,
  output logic [DATA_W+INT_W-1:0] rd_data,
  input  logic                    frame_ack,
  output logic                    err_seq,
  output logic                    err_ovf,
  output logic                    timeout
);

  localparam int ENTRY_W = entry_w(DATA_W, INT_W);

  state_t      state, state_nx;
  logic [3:0]  start_cnt;
  logic [9:0]  to_cnt;
  // idx[2] set means the buffer is full; idx doubles as frame_cnt.
  logic [2:0]  idx;

  logic accept, store, close_last, close_int, close_to, start_end, new_meas;

  assign accept     = TDC_Ovalid && TDC_Oready;
  assign store      = accept && !idx[2];
  assign close_last = accept && TDC_Olast;
  assign close_int  = TDC_INT;
  // Expiry is judged on the current count, so an accepted beat in the
  // expiry cycle is still stored before the frame closes.
  assign close_to   = (to_cnt == 10'(TIMEOUT_CYC - 1));
  assign start_end  = (start_cnt == 4'(START_CYC - 1));
  assign new_meas   = (state == IDLE) && meas_req;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (meas_req) state_nx = START;
      START:   if (start_end) state_nx = COLLECT;
      COLLECT: if (close_last || close_int || close_to) state_nx = DONE;
      DONE:    if (frame_ack) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      TDC_start   <= 1'b0;
      TDC_Oready  <= 1'b0;
      frame_valid <= 1'b0;
      start_cnt   <= '0;
      to_cnt      <= '0;
      idx         <= '0;
      err_seq     <= 1'b0;
      err_ovf     <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_nx;
      // Outputs decoded from the next state so they are registered yet
      // line up exactly with the state they belong to.
      TDC_start   <= (state_nx == START);
      TDC_Oready  <= (state_nx == COLLECT);
      frame_valid <= (state_nx == DONE);

      start_cnt <= (state == START) ? start_cnt + 4'd1 : 4'd0;

      if (state == COLLECT) begin
        to_cnt <= accept ? 10'd0 : to_cnt + 10'd1;
      end else begin
        to_cnt <= '0;
      end

      if (new_meas) begin
        idx     <= '0;
        err_seq <= 1'b0;
        err_ovf <= 1'b0;
        timeout <= 1'b0;
      end else begin
        if (store) begin
          idx <= idx + 3'd1;
          if (TDC_Onum != idx[1:0]) err_seq <= 1'b1;
        end
        if (accept && idx[2]) err_ovf <= 1'b1;
        if ((state == COLLECT) && close_to && !close_last && !close_int) begin
          timeout <= 1'b1;
        end
      end
    end
  end

  assign frame_cnt = idx;

  tdc_rx_fbuf #(
    .ENTRY_W (ENTRY_W)
  ) u_fbuf (
    .clk     (clk),
    .wr_en   (store),
    .wr_idx  (idx[1:0]),
    .wr_data ({TDC_Oint, TDC_Odata}),
    .rd_idx  (rd_addr),
    .rd_data (rd_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_tdc_stream_rx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : tb_tdc_stream_rx                                     |
// | Description : Self-checking bench for tdc_stream_rx with a         |
// |               transaction-level reference model of the frame.      |
// | Revision    : 1.0  initial release                                 |
// +--------------------------------------------------------------------+
module tb_tdc_stream_rx;

  localparam int DATA_W      = 15;
  localparam int INT_W       = 5;
  localparam int START_CYC   = 2;
  localparam int TIMEOUT_CYC = 64;
  localparam int EW          = DATA_W + INT_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              meas_req = 1'b0;
  logic              TDC_start;
  logic [DATA_W-1:0] TDC_Odata = '0;
  logic [INT_W-1:0]  TDC_Oint = '0;
  logic [1:0]        TDC_Onum = '0;
  logic              TDC_Olast = 1'b0;
  logic              TDC_Ovalid = 1'b0;
  logic              TDC_Oready;
  logic              TDC_INT = 1'b0;
  logic              frame_valid;
  logic [2:0]        frame_cnt;
  logic [1:0]        rd_addr = '0;
  logic [EW-1:0]     rd_data;
  logic              frame_ack = 1'b0;
  logic              err_seq, err_ovf, timeout;

  always #5 clk = ~clk;

  tdc_stream_rx #(
    .DATA_W(DATA_W), .INT_W(INT_W), .START_CYC(START_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst), .meas_req(meas_req), .TDC_start(TDC_start),
    .TDC_Odata(TDC_Odata), .TDC_Oint(TDC_Oint), .TDC_Onum(TDC_Onum),
    .TDC_Olast(TDC_Olast), .TDC_Ovalid(TDC_Ovalid), .TDC_Oready(TDC_Oready),
    .TDC_INT(TDC_INT), .frame_valid(frame_valid), .frame_cnt(frame_cnt),
    .rd_addr(rd_addr), .rd_data(rd_data), .frame_ack(frame_ack),
    .err_seq(err_seq), .err_ovf(err_ovf), .timeout(timeout)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: list of stored beats plus flags, driven by the
  // frame rules (store up to 4, flag order/overflow, close causes).
  logic [EW-1:0] m_mem [4];
  int            m_idx;
  int            m_tcnt;
  bit            m_seq, m_ovf, m_to, m_coll;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_idx = 0; m_seq = 0; m_ovf = 0; m_to = 0; m_tcnt = 0;
  endtask

  // One clock cycle of stream stimulus; the model decides acceptance.
  task automatic cyc(input bit v, input logic [DATA_W-1:0] d, input logic [INT_W-1:0] it,
                     input logic [1:0] n, input bit l, input bit irq);
    bit acc, expd;
    logic [1:0] want;
    TDC_Ovalid = v; TDC_Odata = d; TDC_Oint = it; TDC_Onum = n;
    TDC_Olast = l; TDC_INT = irq;
    acc  = v && m_coll;
    expd = m_coll && (m_tcnt == TIMEOUT_CYC - 1);
    if (acc) begin
      if (m_idx < 4) begin
        m_mem[m_idx] = {it, d};
        want = 2'(m_idx);
        if (n != want) m_seq = 1;
        m_idx++;
      end else begin
        m_ovf = 1;
      end
    end
    if (m_coll) begin
      if ((acc && l) || irq || expd) begin
        m_coll = 0;
        m_to   = expd && !(acc && l) && !irq;
      end
      m_tcnt = acc ? 0 : m_tcnt + 1;
    end
    tick();
    TDC_Ovalid = 0; TDC_Olast = 0; TDC_INT = 0;
  endtask

  task automatic idle();
    cyc(0, '0, '0, 2'd0, 0, 0);
  endtask

  task automatic begin_frame();
    meas_req = 1;
    model_clear();
    tick();
    meas_req = 0;
    repeat (START_CYC) tick();
    m_coll = 1;
  endtask

  task automatic ack();
    frame_ack = 1;
    tick();
    frame_ack = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) tick();
    checks++;
    if ({TDC_start, TDC_Oready, frame_valid, frame_cnt, err_seq, err_ovf, timeout} !== 9'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 0",
               {TDC_start, TDC_Oready, frame_valid, frame_cnt, err_seq, err_ovf, timeout});
    end
    rst = 0;
    tick();
    checks++;
    if ({TDC_start, TDC_Oready, frame_valid} !== 3'd0) begin
      errors++; $display("FAIL reset_idle: got %b want 000", {TDC_start, TDC_Oready, frame_valid});
    end
  endtask

  task automatic test_normal();
    logic [DATA_W-1:0] dat [4];
    logic [INT_W-1:0]  its [4];
    dat = '{15'h0100, 15'h0200, 15'h0300, 15'h0400};
    its = '{5'd1, 5'd5, 5'd9, 5'd11};
    meas_req = 1;
    model_clear();
    tick();
    meas_req = 0;
    for (int i = 0; i < START_CYC; i++) begin
      checks++;
      if (TDC_start !== 1'b1 || TDC_Oready !== 1'b0) begin
        errors++; $display("FAIL normal_start[%0d]: start=%b ready=%b want 1/0", i, TDC_start, TDC_Oready);
      end
      tick();
    end
    checks++;
    if (TDC_start !== 1'b0 || TDC_Oready !== 1'b1) begin
      errors++; $display("FAIL normal_collect: start=%b ready=%b want 0/1", TDC_start, TDC_Oready);
    end
    m_coll = 1;
    for (int i = 0; i < 4; i++) begin
      cyc(1, dat[i], its[i], 2'(i), i == 3, 0);
      checks++;
      if (frame_valid !== (i == 3)) begin
        errors++; $display("FAIL normal_fv[%0d]: got %b want %b", i, frame_valid, i == 3);
      end
    end
    checks++;
    if (frame_cnt !== 3'd4 || {err_seq, err_ovf, timeout} !== 3'b000 || TDC_Oready !== 1'b0) begin
      errors++; $display("FAIL normal_status: cnt=%0d flags=%b ready=%b want 4/000/0",
                         frame_cnt, {err_seq, err_ovf, timeout}, TDC_Oready);
    end
    rd_addr = 2'd2; #1;
    checks++;
    if (rd_data !== {5'd9, 15'h0300}) begin
      errors++; $display("FAIL normal_rd2: got %h want %h", rd_data, {5'd9, 15'h0300});
    end
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i); #1;
      checks++;
      if (rd_data !== m_mem[i]) begin
        errors++; $display("FAIL normal_rd[%0d]: got %h want %h", i, rd_data, m_mem[i]);
      end
    end
    ack();
    checks++;
    if (frame_valid !== 1'b0) begin
      errors++; $display("FAIL normal_ack: frame_valid=%b want 0", frame_valid);
    end
  endtask

  task automatic test_gap_int();
    begin_frame();
    idle();
    cyc(1, 15'($urandom), 5'($urandom), 2'd0, 0, 0);
    idle(); idle();
    cyc(1, 15'($urandom), 5'($urandom), 2'd1, 0, 0);
    idle();
    cyc(0, '0, '0, 2'd0, 0, 1);
    checks++;
    if (frame_valid !== 1'b1 || frame_cnt !== 3'd2 || {err_seq, err_ovf, timeout} !== 3'b000
        || TDC_Oready !== 1'b0) begin
      errors++; $display("FAIL gap_int_status: fv=%b cnt=%0d flags=%b ready=%b want 1/2/000/0",
                         frame_valid, frame_cnt, {err_seq, err_ovf, timeout}, TDC_Oready);
    end
    // Beat offered and measurement requested while DONE: both ignored.
    meas_req = 1;
    cyc(1, 15'h7fff, 5'h1f, 2'd2, 1, 1);
    meas_req = 0;
    idle();
    checks++;
    if (TDC_start !== 1'b0 || frame_cnt !== 3'd2 || frame_valid !== 1'b1) begin
      errors++; $display("FAIL gap_done_ignore: start=%b cnt=%0d fv=%b want 0/2/1",
                         TDC_start, frame_cnt, frame_valid);
    end
    for (int i = 0; i < 2; i++) begin
      rd_addr = 2'(i); #1;
      checks++;
      if (rd_data !== m_mem[i]) begin
        errors++; $display("FAIL gap_rd[%0d]: got %h want %h", i, rd_data, m_mem[i]);
      end
    end
    ack();
    checks++;
    if (frame_valid !== 1'b0) begin
      errors++; $display("FAIL gap_ack: frame_valid=%b want 0", frame_valid);
    end
  endtask

  task automatic test_timeout();
    begin_frame();
    for (int i = 0; i < TIMEOUT_CYC + 8 && m_coll; i++) begin
      idle();
      checks++;
      if (frame_valid !== !m_coll) begin
        errors++; $display("FAIL timeout_fv[%0d]: got %b want %b", i, frame_valid, !m_coll);
      end
    end
    checks++;
    if (m_coll || timeout !== 1'b1 || frame_cnt !== 3'd0 || TDC_Oready !== 1'b0) begin
      errors++; $display("FAIL timeout_status: to=%b cnt=%0d ready=%b want 1/0/0",
                         timeout, frame_cnt, TDC_Oready);
    end
    ack();
    checks++;
    if (frame_valid !== 1'b0 || TDC_start !== 1'b0) begin
      errors++; $display("FAIL timeout_ack: fv=%b start=%b want 0/0", frame_valid, TDC_start);
    end
  endtask

  task automatic test_errors();
    logic [1:0] nums [5];
    nums = '{2'd0, 2'd2, 2'd2, 2'd3, 2'd0};
    begin_frame();
    for (int i = 0; i < 5; i++) begin
      cyc(1, 15'(16'h1000 * (i + 1) + i), 5'(i + 3), nums[i], i == 4, 0);
    end
    checks++;
    if ({err_seq, err_ovf, timeout} !== 3'b110 || frame_cnt !== 3'd4 || frame_valid !== 1'b1) begin
      errors++; $display("FAIL errors_status: flags=%b cnt=%0d fv=%b want 110/4/1",
                         {err_seq, err_ovf, timeout}, frame_cnt, frame_valid);
    end
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i); #1;
      checks++;
      if (rd_data !== m_mem[i]) begin
        errors++; $display("FAIL errors_rd[%0d]: got %h want %h", i, rd_data, m_mem[i]);
      end
    end
    ack();
  endtask

  task automatic test_simul();
    logic [DATA_W-1:0] d;
    begin_frame();
    repeat (TIMEOUT_CYC - 1) idle();
    d = 15'($urandom);
    cyc(1, d, 5'd7, 2'd0, 1, 1);
    checks++;
    if (frame_valid !== 1'b1 || timeout !== 1'b0 || frame_cnt !== 3'd1) begin
      errors++; $display("FAIL simul_status: fv=%b to=%b cnt=%0d want 1/0/1",
                         frame_valid, timeout, frame_cnt);
    end
    rd_addr = 2'd0; #1;
    checks++;
    if (rd_data !== {5'd7, d}) begin
      errors++; $display("FAIL simul_rd0: got %h want %h", rd_data, {5'd7, d});
    end
    ack();
  endtask

  task automatic test_reset_mid();
    begin_frame();
    cyc(1, 15'h1234, 5'd3, 2'd0, 0, 0);
    #2 rst = 1;
    #1;
    m_coll = 0;
    checks++;
    if ({TDC_Oready, frame_valid, TDC_start, frame_cnt} !== 6'd0) begin
      errors++; $display("FAIL rstmid_async: ready=%b fv=%b start=%b cnt=%0d want 0",
                         TDC_Oready, frame_valid, TDC_start, frame_cnt);
    end
    @(posedge clk); #1;
    rst = 0;
    tick();
    begin_frame();
    checks++;
    if (frame_cnt !== 3'd0 || TDC_Oready !== 1'b1) begin
      errors++; $display("FAIL rstmid_restart: cnt=%0d ready=%b want 0/1", frame_cnt, TDC_Oready);
    end
    for (int i = 0; i < 4; i++) cyc(1, 15'($urandom), 5'($urandom), 2'(i), i == 3, 0);
    checks++;
    if (frame_cnt !== 3'd4 || {err_seq, err_ovf, timeout} !== 3'b000) begin
      errors++; $display("FAIL rstmid_frame: cnt=%0d flags=%b want 4/000", frame_cnt,
                         {err_seq, err_ovf, timeout});
    end
    rd_addr = 2'd0; #1;
    checks++;
    if (rd_data !== m_mem[0]) begin
      errors++; $display("FAIL rstmid_rd0: got %h want %h", rd_data, m_mem[0]);
    end
    ack();
  endtask

  task automatic test_random();
    for (int f = 0; f < 24; f++) begin
      int nb, mode;
      logic [1:0] n;
      begin_frame();
      nb   = int'($urandom_range(1, 6));
      mode = int'($urandom_range(0, 2));
      for (int b = 0; b < nb; b++) begin
        repeat ($urandom_range(0, 2)) idle();
        if (m_idx >= 4)            n = 2'd0;
        else if ($urandom_range(0, 3) == 0) n = 2'($urandom);
        else                       n = 2'(m_idx);
        cyc(1, 15'($urandom), 5'($urandom), n, (b == nb - 1) && mode == 0,
            (b == nb - 1) && mode == 1);
      end
      if (mode == 2) cyc(0, '0, '0, 2'd0, 0, 1);
      checks++;
      if (m_coll || frame_valid !== 1'b1 || frame_cnt !== 3'(m_idx) || err_seq !== m_seq
          || err_ovf !== m_ovf || timeout !== m_to) begin
        errors++;
        $display("FAIL rand%0d_status: fv=%b cnt=%0d seq=%b ovf=%b to=%b want 1/%0d/%b/%b/%b",
                 f, frame_valid, frame_cnt, err_seq, err_ovf, timeout, m_idx, m_seq, m_ovf, m_to);
      end
      for (int i = 0; i < m_idx; i++) begin
        rd_addr = 2'(i); #1;
        checks++;
        if (rd_data !== m_mem[i]) begin
          errors++; $display("FAIL rand%0d_rd[%0d]: got %h want %h", f, i, rd_data, m_mem[i]);
        end
      end
      ack();
      checks++;
      if (frame_valid !== 1'b0) begin
        errors++; $display("FAIL rand%0d_ack: fv=%b want 0", f, frame_valid);
      end
    end
  endtask

  initial begin
    m_coll = 0;
    model_clear();
    test_reset();
    test_normal();
    test_gap_int();
    test_timeout();
    test_errors();
    test_simul();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
